// File: rtl/dmem_pkg.sv
// Shared types, funct3 encodings and request checking for the data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // The RAM base is word-aligned, so offset[1:0] equals the byte lane of the address.
   function automatic logic access_err(input logic        wren,
                                       input logic [2:0]  funct3,
                                       input logic [31:0] offset,
                                       input logic [31:0] limit);
      logic illegal;
      logic misaligned;
      illegal    = 1'b0;
      misaligned = 1'b0;
      case (funct3)
         F3_B:    illegal = 1'b0;
         F3_H:    misaligned = offset[0];
         F3_W:    misaligned = (offset[1:0] != 2'b00);
         F3_BU:   illegal = wren;
         F3_HU: begin
            illegal    = wren;
            misaligned = offset[0];
         end
         default: illegal = 1'b1;
      endcase
      return illegal | misaligned | (offset >= limit);
   endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store request/response bundle between the LSU initiator and the data memory.
interface dmem_if;
   import dmem_pkg::*;

   // Handshake: the master raises req and holds req plus every request field stable
   // until it sees ack; ack is a one-cycle pulse carrying err and rdata. A new request
   // may be presented (or req simply kept high) in the ack cycle itself.
   logic        req;
   logic [31:0] addr;
   logic        wren;
   logic [2:0]  funct3;
   logic [31:0] wdata;
   logic        ack;
   logic        err;
   logic [31:0] rdata;
   dmem_state_t dbg_state;

   modport master (
      output req, addr, wren, funct3, wdata,
      input  ack, err, rdata, dbg_state
   );

   modport slave (
      input  req, addr, wren, funct3, wdata,
      output ack, err, rdata, dbg_state
   );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, load select and extend.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  lane,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_word,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_lanes,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Write data is replicated across lanes so only the byte enables depend on the lane.
   always_comb begin
      byte_en     = 4'b0000;
      wdata_lanes = 32'h0000_0000;
      case (funct3[1:0])
         2'b00: begin
            byte_en     = 4'b0001 << lane;
            wdata_lanes = {4{wdata[7:0]}};
         end
         2'b01: begin
            byte_en     = lane[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{wdata[15:0]}};
         end
         default: begin
            byte_en     = 4'b1111;
            wdata_lanes = wdata;
         end
      endcase
   end

   always_comb begin
      byte_sel  = rdata_word[{lane, 3'b000} +: 8];
      half_sel  = lane[1] ? rdata_word[31:16] : rdata_word[15:0];
      load_data = rdata_word;
      case (funct3)
         F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_data = {24'h00_0000, byte_sel};
         F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_data = {16'h0000, half_sel};
         default: load_data = rdata_word;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the LSU: one request at a time, programmable wait states,
// byte-lane RAM writes, extended loads and an error completion for rejected accesses.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 2048,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input logic   i_clk,
   input logic   i_reset,
   dmem_if.slave bus
);

   localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] LIMIT     = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   dmem_state_t state, state_d;
   logic [3:0]  cnt, cnt_d;
   logic        latch_en;
   logic        access_en;
   logic        ack_d;

   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic        lat_wren;
   logic [2:0]  lat_f3;
   logic        lat_err;
   logic        req_err;

   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic        acc_wren;
   logic [2:0]  acc_f3;
   logic [31:0] acc_offset;
   logic [AW-1:0] word_idx;
   logic        unused_offset_bits;

   logic [3:0]  byte_en;
   logic [31:0] wdata_lanes;
   logic [31:0] load_data;
   logic [31:0] ram_q;

   logic        ack_q;
   logic        err_q;
   logic [31:0] rdata_q;

   logic [31:0] ram [DEPTH_WORDS];

   assign req_err = access_err(bus.wren, bus.funct3, bus.addr - BASE_ADDR, LIMIT);

   // With zero wait states the access happens on the accepting edge, before the latch
   // is visible, so the access path reads the bus directly while idle.
   always_comb begin
      if (state == IDLE) begin
         acc_addr  = bus.addr;
         acc_wdata = bus.wdata;
         acc_wren  = bus.wren;
         acc_f3    = bus.funct3;
      end else begin
         acc_addr  = lat_addr;
         acc_wdata = lat_wdata;
         acc_wren  = lat_wren;
         acc_f3    = lat_f3;
      end
   end

   assign acc_offset         = acc_addr - BASE_ADDR;
   assign word_idx           = acc_offset[AW+1:2];
   assign unused_offset_bits = ^acc_offset[31:AW+2];

   dmem_lane_align u_lane_align (
      .lane        (acc_offset[1:0]),
      .funct3      (acc_f3),
      .wdata       (acc_wdata),
      .rdata_word  (ram_q),
      .byte_en     (byte_en),
      .wdata_lanes (wdata_lanes),
      .load_data   (load_data)
   );

   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      latch_en  = 1'b0;
      access_en = 1'b0;
      ack_d     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req) begin
               latch_en = 1'b1;
               if (req_err) begin
                  state_d = RESP;
               end else if (WAIT_CYCLES == 0) begin
                  state_d   = RESP;
                  access_en = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               state_d   = RESP;
               access_en = 1'b1;
            end else begin
               cnt_d = cnt - 4'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
            ack_d   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // ack/err/rdata are registered on the edge leaving RESP, so the ack cycle is
   // already an IDLE cycle and a held request is taken on the edge that ends it.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0000_0000;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         ack_q <= ack_d;
         err_q <= ack_d & lat_err;
         if (ack_d) begin
            rdata_q <= (lat_err | lat_wren) ? 32'h0000_0000 : load_data;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (latch_en) begin
         lat_addr  <= bus.addr;
         lat_wdata <= bus.wdata;
         lat_wren  <= bus.wren;
         lat_f3    <= bus.funct3;
         lat_err   <= req_err;
      end
   end

   // Reset gates the write enable so a store cut off by reset never reaches the RAM.
   always_ff @(posedge i_clk) begin
      if (i_reset && access_en) begin
         if (acc_wren) begin
            for (int b = 0; b < 4; b++) begin
               if (byte_en[b]) begin
                  ram[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
               end
            end
         end else begin
            ram_q <= ram[word_idx];
         end
      end
   end

   assign bus.ack       = ack_q;
   assign bus.err       = err_q;
   assign bus.rdata     = rdata_q;
   assign bus.dbg_state = state;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the core's load/store interface. It services one request at a time from the LSU-side initiator over a req/ack handshake. Backing store is a word-organised data RAM with byte-lane writes; loads are sign- or zero-extended. Access timing is programmable through wait states, and misaligned, out-of-range and illegal accesses complete with an error flag. It sits behind the LSU as the data-memory target, alongside the instruction memory.

## Interface
- DEPTH_WORDS, 2048: RAM depth in 32-bit words (8 KiB).
- BASE_ADDR, 32'h0000_2000: byte address of word 0; must be word-aligned.
- WAIT_CYCLES, 1: wait states before the access, 0..15.
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_req  in  1  request valid; initiator holds it and all request fields stable until o_ack.
- i_addr  in  32  byte address.
- i_wren  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32I funct3. Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Stores: SB 000, SH 001, SW 010.
- i_wdata  in  32  store data, right-aligned.
- o_ack  out  1  one-cycle completion pulse.
- o_err  out  1  valid with o_ack; access rejected.
- o_rdata  out  32  load result, valid with o_ack.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: on i_req=1 at edge k, latch address, wren, funct3 and wdata, then check the request.
  - Error if funct3 is illegal: 011, 110 or 111; or 100 or 101 with wren=1.
  - Error if misaligned: half-word access with addr[0]=1, or word access with addr[1:0]!=0.
  - Error if out of range: (addr − BASE_ADDR) ≥ DEPTH_WORDS·4 unsigned. This covers addresses below base via wrap-around.
  - Erroneous request → RESP with o_err=1. No RAM access.
  - Valid request with WAIT_CYCLES=0 → RESP, performing the access at edge k.
  - Valid request otherwise → WAIT with counter = WAIT_CYCLES−1.
- WAIT: decrement the counter each edge. When the counter is 0, go to RESP and perform the access at that edge.
- Access uses the latched fields; word index = (addr − BASE_ADDR)[..:2].
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Loads select a byte or half-word by lane and extend: LB/LH sign-extend, LBU/LHU zero-extend. The result is registered into o_rdata.
- RESP: o_ack=1 for exactly one cycle, then IDLE. i_req is ignored in RESP.
- o_rdata = 0 on stores and errors; it holds its value outside ack cycles.
- i_req deasserted during WAIT (protocol violation): the transaction still completes and acks.
- RAM contents are not initialised and not cleared by reset.

## Timing
- Reset (i_reset=0 at an edge): state IDLE, counter 0, o_ack=0, o_err=0, o_rdata=0.
- Reset has priority over an access at the same edge. A pending store dropped by reset leaves the RAM unchanged.
- Valid access sampled at edge k: RAM write or read at edge k+WAIT_CYCLES; o_ack high from edge k+WAIT_CYCLES+1 until edge k+WAIT_CYCLES+2.
- Error sampled at edge k: o_ack/o_err high from edge k+1 until edge k+2, independent of WAIT_CYCLES.
- Minimum request period = WAIT_CYCLES+2 cycles.
  - A held i_req is re-accepted in the first IDLE cycle after ack.
  - The initiator must drop i_req in the ack cycle if it has no further request.
- Read-after-write to the same word with back-to-back transactions returns the new data.

## Structure
- Package dmem_pkg holds:
  - the state enum (IDLE/WAIT/RESP),
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU),
  - the legality/alignment check as a function.
- Sub-module dmem_lane_align (combinational) provides:
  - store byte-enable and shifted write data from addr[1:0], funct3 and wdata;
  - load lane selection and sign/zero extension.
- RAM is a behavioural array with per-byte write enables, for inferred block RAM.

## Test plan
- WAIT_CYCLES=1: SW 0x2000 with 0xDEADBEEF, then LW 0x2000. Each ack arrives 2 cycles after sampling; LW o_rdata=0xDEADBEEF, o_err=0.
- SB 0x2003 with 0x000000A5. Then LB 0x2003 → 0xFFFFFFA5; LBU 0x2003 → 0x000000A5; LW 0x2000 → 0xA5ADBEEF; LHU 0x2002 → 0x0000A5AD.
- LH 0x2001, SW 0x2002 and funct3=011 load: each acks 1 cycle after sampling with o_err=1 and o_rdata=0. A later LW 0x2000 is unchanged.
- SW 0x1FFC and LW 0x4000 (DEPTH_WORDS=2048): both o_err=1. LW 0x3FFC: o_err=0.
- WAIT_CYCLES=3: drive i_reset=0 during the second WAIT cycle of SW 0x2000 with 0x12345678. No ack; a subsequent LW 0x2000 still returns 0xA5ADBEEF.
- WAIT_CYCLES=0, i_req held high with alternating SW 0x2004 with 0x11111111 / LW 0x2004. Ack every 2nd cycle; the LW returns 0x11111111.
